// File: rtl/simple_uart.sv
// ============================================================================
// simple_uart : memory-mapped 8N1 UART (TX shifter + RX FIFO) on picorv32 bus
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module simple_uart #(
   parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
   parameter logic [15:0] DEFAULT_DIV = 16'd868,
   parameter int          RX_DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic [31:0] mem_rdata,
   output logic        uart_txd,
   input  logic        uart_rxd
);

   localparam int         AW         = $clog2(RX_DEPTH);
   localparam logic [AW:0] FIFO_FULL = (AW+1)'(RX_DEPTH);
   localparam logic [15:0] MIN_DIV   = 16'd4;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   // ---------------------------------------------------------------------
   // Bus decode
   // ---------------------------------------------------------------------
   logic [1:0]  offset;
   logic        sel;
   logic        is_write;
   logic        data_wr_req;
   logic        accept;
   logic [31:0] rd_val;
   logic [31:0] status;

   logic [15:0] div;
   logic [15:0] eff_div;

   logic        tx_busy;
   logic [8:0]  tx_shift;
   logic [3:0]  tx_bits;
   logic [15:0] tx_cnt;
   logic [15:0] tx_div;

   logic        rxd_s1;
   logic        rxd_sync;
   logic        rxd_prev;
   rx_state_t   rx_state;
   logic [15:0] rx_cnt;
   logic [15:0] rx_div;
   logic [15:0] rx_half;
   logic [2:0]  rx_bits;
   logic [7:0]  rx_shift;
   logic        stop_sample;
   logic        push_req;

   logic [7:0]  fifo_mem [RX_DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [AW:0] fifo_count;
   logic        fifo_empty;
   logic        fifo_full;
   logic        pop;
   logic        push_ok;

   logic        overrun;
   logic        frame_err;

   logic        unused_bits;

   assign offset      = mem_addr[3:2];
   assign sel         = (mem_addr[31:4] == BASE_ADDR[31:4]);
   assign is_write    = |mem_wstrb;
   assign data_wr_req = (offset == 2'd0) & mem_wstrb[0];
   // A DATA write that would clobber an active frame is held off until TX idles.
   assign accept      = mem_valid & sel & ~mem_ready & ~(data_wr_req & tx_busy);

   assign eff_div     = (div < MIN_DIV) ? MIN_DIV : div;

   assign fifo_count  = wr_ptr - rd_ptr;
   assign fifo_empty  = (wr_ptr == rd_ptr);
   assign fifo_full   = (fifo_count == FIFO_FULL);
   assign pop         = accept & ~is_write & (offset == 2'd0) & ~fifo_empty;

   assign rx_half     = {1'b0, rx_div[15:1]};
   assign stop_sample = (rx_state == RX_STOP) && (rx_cnt == rx_div - 16'd1);
   assign push_req    = stop_sample & rxd_sync;
   // Popping on the same edge frees the slot, so a full FIFO still accepts.
   assign push_ok     = push_req & (~fifo_full | pop);

   assign status      = {27'd0, frame_err, overrun, fifo_full, ~fifo_empty, tx_busy};

   assign unused_bits = &{1'b0, mem_addr[1:0], mem_wdata[31:16]};

   always_comb begin
      rd_val = 32'd0;
      case (offset)
         2'd0: if (!fifo_empty) rd_val = {23'd0, 1'b1, fifo_mem[rd_ptr[AW-1:0]]};
         2'd1: rd_val = status;
         2'd2: rd_val = {16'd0, div};
         default: rd_val = 32'd0;
      endcase
   end

   // ---------------------------------------------------------------------
   // Bus response and register writes
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_ready <= 1'b0;
         mem_rdata <= 32'd0;
         div       <= DEFAULT_DIV;
      end else begin
         mem_ready <= accept;
         mem_rdata <= (accept && !is_write) ? rd_val : 32'd0;
         if (accept && (offset == 2'd2)) begin
            if (mem_wstrb[0]) div[7:0]  <= mem_wdata[7:0];
            if (mem_wstrb[1]) div[15:8] <= mem_wdata[15:8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (accept && (offset == 2'd1) && mem_wstrb[0]) begin
            if (mem_wdata[3]) overrun   <= 1'b0;
            if (mem_wdata[4]) frame_err <= 1'b0;
         end
         if (push_req && fifo_full && !pop) overrun <= 1'b1;
         if (stop_sample && !rxd_sync)      frame_err <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // TX shifter: start bit goes out on the accepting edge
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         uart_txd <= 1'b1;
         tx_busy  <= 1'b0;
         tx_shift <= 9'h1FF;
         tx_bits  <= 4'd0;
         tx_cnt   <= 16'd0;
         tx_div   <= MIN_DIV;
      end else if (accept && data_wr_req) begin
         uart_txd <= 1'b0;
         tx_busy  <= 1'b1;
         tx_shift <= {1'b1, mem_wdata[7:0]};
         tx_bits  <= 4'd9;
         tx_cnt   <= eff_div - 16'd1;
         tx_div   <= eff_div;
      end else if (tx_busy) begin
         if (tx_cnt == 16'd0) begin
            if (tx_bits == 4'd0) begin
               tx_busy  <= 1'b0;
               uart_txd <= 1'b1;
            end else begin
               uart_txd <= tx_shift[0];
               tx_shift <= {1'b1, tx_shift[8:1]};
               tx_bits  <= tx_bits - 4'd1;
               tx_cnt   <= tx_div - 16'd1;
            end
         end else begin
            tx_cnt <= tx_cnt - 16'd1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // RX synchronizer and receive FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxd_s1   <= 1'b1;
         rxd_sync <= 1'b1;
         rxd_prev <= 1'b1;
      end else begin
         rxd_s1   <= uart_rxd;
         rxd_sync <= rxd_s1;
         rxd_prev <= rxd_sync;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= 16'd0;
         rx_div   <= MIN_DIV;
         rx_bits  <= 3'd0;
         rx_shift <= 8'd0;
      end else begin
         case (rx_state)
            RX_IDLE: begin
               if (rxd_prev && !rxd_sync) begin
                  rx_state <= RX_START;
                  rx_cnt   <= 16'd0;
                  rx_div   <= eff_div;
               end
            end
            RX_START: begin
               if (rx_cnt == rx_half - 16'd1) begin
                  rx_cnt  <= 16'd0;
                  rx_bits <= 3'd0;
                  rx_state <= rxd_sync ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt <= rx_cnt + 16'd1;
               end
            end
            RX_DATA: begin
               if (rx_cnt == rx_div - 16'd1) begin
                  rx_cnt   <= 16'd0;
                  rx_shift <= {rxd_sync, rx_shift[7:1]};
                  if (rx_bits == 3'd7) rx_state <= RX_STOP;
                  else                 rx_bits  <= rx_bits + 3'd1;
               end else begin
                  rx_cnt <= rx_cnt + 16'd1;
               end
            end
            RX_STOP: begin
               if (stop_sample) rx_state <= RX_IDLE;
               else             rx_cnt   <= rx_cnt + 16'd1;
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // RX FIFO
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr[AW-1:0]] <= rx_shift;
   end

endmodule

`default_nettype wire

// File: tb/tb_simple_uart.sv
// Directed/randomized bench for simple_uart with a queue-based UART reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_simple_uart;

   localparam logic [31:0] BASE    = 32'h2000_0000;
   localparam int          TIMEOUT = 2000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_valid = 1'b0;
   logic        mem_ready;
   logic [31:0] mem_addr = 32'd0;
   logic [31:0] mem_wdata = 32'd0;
   logic [3:0]  mem_wstrb = 4'd0;
   logic [31:0] mem_rdata;
   logic        uart_txd;
   logic        uart_rxd = 1'b1;

   always #5 clk = ~clk;

   simple_uart #(
      .BASE_ADDR  (BASE),
      .DEFAULT_DIV(16'd868),
      .RX_DEPTH   (4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .mem_valid(mem_valid),
      .mem_ready(mem_ready),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb),
      .mem_rdata(mem_rdata),
      .uart_txd (uart_txd),
      .uart_rxd (uart_rxd)
   );

   int checks   = 0;
   int failures = 0;

   logic       capture = 1'b0;
   logic       txlog[$];
   logic [7:0] txq[$];

   logic [7:0] rxq[$];
   logic       m_overrun   = 1'b0;
   logic       m_frame_err = 1'b0;

   always @(negedge clk) if (capture) txlog.push_back(uart_txd);

   initial begin
      #3ms;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_status(input logic busy);
      return {27'd0, m_frame_err, m_overrun, rxq.size() == 4, rxq.size() != 0, busy};
   endfunction

   task automatic bus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                      output logic [31:0] rdata, output int lat);
      @(posedge clk); #1;
      mem_valid = 1'b1;
      mem_addr  = addr;
      mem_wdata = wdata;
      mem_wstrb = wstrb;
      lat       = 0;
      rdata     = 32'hDEAD_BEEF;
      while (lat < TIMEOUT) begin
         @(posedge clk); #1;
         lat++;
         if (mem_ready) begin
            rdata = mem_rdata;
            break;
         end
      end
      mem_valid = 1'b0;
      mem_wstrb = 4'd0;
   endtask

   task automatic rd(input logic [3:0] off, input logic [31:0] exp, input string tag);
      logic [31:0] d;
      int          lat;
      bus(BASE + {28'd0, off}, 32'd0, 4'd0, d, lat);
      check({tag, "_lat"}, 32'(lat), 32'd1);
      check(tag, d, exp);
   endtask

   task automatic wr(input logic [3:0] off, input logic [31:0] data, input logic [3:0] strb,
                     input int exp_lat, input string tag);
      logic [31:0] d;
      int          lat;
      bus(BASE + {28'd0, off}, data, strb, d, lat);
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
   endtask

   task automatic rd_data(input string tag);
      logic [31:0] exp;
      exp = 32'd0;
      if (rxq.size() != 0) exp = {23'd0, 1'b1, rxq.pop_front()};
      rd(4'h0, exp, tag);
   endtask

   task automatic rx_bit(input logic v, input int eff);
      uart_rxd = v;
      repeat (eff) @(negedge clk);
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop, input int eff);
      @(negedge clk);
      rx_bit(1'b0, eff);
      for (int i = 0; i < 8; i++) rx_bit(b[i], eff);
      rx_bit(stop, eff);
      uart_rxd = 1'b1;
      repeat (6) @(negedge clk);
      if (stop) begin
         if (rxq.size() < 4) rxq.push_back(b);
         else                m_overrun = 1'b1;
      end else begin
         m_frame_err = 1'b1;
      end
   endtask

   // Frames in txq must appear back to back in txlog, one idle sample between them.
   task automatic check_tx(input int eff, input string tag);
      int         idx;
      int         zeros;
      logic [9:0] frame;
      idx = -1;
      for (int i = 0; i < txlog.size(); i++) begin
         if (txlog[i] == 1'b0) begin
            idx = i;
            break;
         end
      end
      check({tag, "_found"}, {31'd0, idx >= 0}, 32'd1);
      if (idx < 0) return;
      for (int n = 0; n < txq.size(); n++) begin
         frame = {1'b1, txq[n], 1'b0};
         for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < eff; j++) begin
               if (idx >= txlog.size()) begin
                  check({tag, "_len"}, 32'(txlog.size()), 32'(idx + 1));
                  return;
               end
               check({tag, "_bit"}, {31'd0, txlog[idx]}, {31'd0, frame[k]});
               idx++;
            end
         end
         if (n + 1 < txq.size()) begin
            if (idx >= txlog.size()) begin
               check({tag, "_len"}, 32'(txlog.size()), 32'(idx + 1));
               return;
            end
            check({tag, "_gap"}, {31'd0, txlog[idx]}, 32'd1);
            idx++;
         end
      end
      zeros = 0;
      for (int i = idx; i < txlog.size(); i++) if (!txlog[i]) zeros++;
      check({tag, "_idle"}, 32'(zeros), 32'd0);
   endtask

   task automatic tx_frames(input int eff, input int count, input string tag);
      logic [7:0] b;
      txlog.delete();
      txq.delete();
      capture = 1'b1;
      for (int n = 0; n < count; n++) begin
         b = (n == 0 && count == 1 && eff == 4 && tag == "tx1") ? 8'h55 : 8'($urandom);
         txq.push_back(b);
         wr(4'h0, {24'd0, b}, 4'b0001, (n == 0) ? 1 : 10 * eff, {tag, "_wr"});
         check({tag, "_fall"}, {31'd0, uart_txd}, 32'd0);
      end
      rd(4'h4, exp_status(1'b1), {tag, "_busy"});
      repeat (10 * eff + 6) @(posedge clk);
      rd(4'h4, exp_status(1'b0), {tag, "_done"});
      capture = 1'b0;
      check_tx(eff, tag);
   endtask

   initial begin
      int d;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", {31'd0, mem_ready}, 32'd0);
      check("rst_rdata", mem_rdata, 32'd0);
      check("rst_txd", {31'd0, uart_txd}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      rd(4'h4, 32'd0, "rst_status");
      rd(4'h8, 32'd868, "rst_div");
      rd(4'hC, 32'd0, "resv_rd");
      wr(4'hC, $urandom, 4'hF, 1, "resv_wr");
      rd(4'h0, 32'd0, "empty_data");

      // Per-byte DIV strobes: 0x0364 -> 0x0304 -> 0x0004
      wr(4'h8, 32'h1234_5604 | 32'h0000_0000, 4'b0001, 1, "div_lo");
      rd(4'h8, 32'h0000_0304, "div_lo_rd");
      wr(4'h8, 32'hFFFF_0000, 4'b0010, 1, "div_hi");
      rd(4'h8, 32'h0000_0004, "div_hi_rd");

      // ready lasts one cycle even if valid stays high
      @(posedge clk); #1;
      mem_valid = 1'b1;
      mem_addr  = BASE + 32'h8;
      mem_wstrb = 4'd0;
      @(posedge clk); #1;
      check("hold_ready1", {31'd0, mem_ready}, 32'd1);
      check("hold_rdata1", mem_rdata, 32'd4);
      @(posedge clk); #1;
      check("hold_ready0", {31'd0, mem_ready}, 32'd0);
      check("hold_rdata0", mem_rdata, 32'd0);
      mem_valid = 1'b0;

      // TX
      tx_frames(4, 1, "tx1");
      tx_frames(4, 2, "tx2");
      wr(4'h8, 32'd2, 4'b0011, 1, "div2");
      rd(4'h8, 32'd2, "div2_rd");
      tx_frames(4, 1, "txmin");
      d = $urandom_range(9, 5);
      wr(4'h8, 32'(d), 4'b0011, 1, "divr");
      tx_frames(d, 2, "txr");
      wr(4'h8, 32'd4, 4'b0011, 1, "div4");

      // RX single byte
      send_rx(8'hA3, 1'b1, 4);
      rd(4'h4, exp_status(1'b0), "rx1_status");
      rd_data("rx1_data");
      rd(4'h4, exp_status(1'b0), "rx1_status2");
      rd_data("rx1_empty");

      // Overrun on the fifth unread byte
      for (int i = 0; i < 5; i++) send_rx(8'($urandom), 1'b1, 4);
      rd(4'h4, exp_status(1'b0), "ovr_status");
      for (int i = 0; i < 4; i++) rd_data("ovr_data");
      rd(4'h4, exp_status(1'b0), "ovr_status2");
      wr(4'h4, 32'h8, 4'b0001, 1, "ovr_clr");
      m_overrun = 1'b0;
      rd(4'h4, exp_status(1'b0), "ovr_status3");

      // Framing error
      send_rx(8'($urandom), 1'b0, 4);
      rd(4'h4, exp_status(1'b0), "ferr_status");
      rd_data("ferr_data");
      wr(4'h4, 32'h10, 4'b0001, 1, "ferr_clr");
      m_frame_err = 1'b0;
      rd(4'h4, exp_status(1'b0), "ferr_status2");

      // One-cycle glitch is rejected
      @(negedge clk);
      uart_rxd = 1'b0;
      @(negedge clk);
      uart_rxd = 1'b1;
      repeat (20) @(negedge clk);
      rd(4'h4, exp_status(1'b0), "glitch_status");

      // RX at a random divisor
      d = $urandom_range(9, 5);
      wr(4'h8, 32'(d), 4'b0011, 1, "rxdiv");
      send_rx(8'($urandom), 1'b1, d);
      send_rx(8'($urandom), 1'b1, d);
      rd(4'h4, exp_status(1'b0), "rxr_status");
      rd_data("rxr_data0");
      rd_data("rxr_data1");

      // Reset in the middle of a TX frame and an RX frame
      wr(4'h8, 32'd4, 4'b0011, 1, "rst_div4");
      wr(4'h0, 32'h00, 4'b0001, 1, "rst_tx");
      repeat (8) @(posedge clk);
      @(negedge clk);
      uart_rxd = 1'b0;
      repeat (12) @(negedge clk);
      check("rst_pre_txd", {31'd0, uart_txd}, 32'd0);
      rst_n = 1'b0;
      #1;
      check("rst_mid_txd", {31'd0, uart_txd}, 32'd1);
      check("rst_mid_ready", {31'd0, mem_ready}, 32'd0);
      repeat (3) @(posedge clk);
      uart_rxd = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      rxq.delete();
      rd(4'h4, 32'd0, "rst2_status");
      rd(4'h8, 32'd868, "rst2_div");
      repeat (60) @(posedge clk);
      rd(4'h4, 32'd0, "rst2_status2");
      rd(4'h0, 32'd0, "rst2_data");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
